sync_debounce_edge: RTL and testbench
=====================================

# sync_debounce_edge

Debounce and edge-qualify stage that consumes the output of the two-flop level synchronizer in the same clock domain. A level change on `sync_in` is accepted only after it has held for DEBOUNCE_CYCLES consecutive enabled samples. Accepted changes produce a clean `level_out`, single-cycle `rise_pulse` and `fall_pulse` strobes, and an optional saturating count of accepted rising edges.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive equal samples required to accept a level change; legal range 1..65535
- CNT_WIDTH, 8, width of `event_cnt`; legal range 1..32
- clk  in  1  system clock; all logic rises on posedge
- rst  in  1  asynchronous, active-low reset: asserts immediately, deasserts synchronously to clk outside this block
- sync_in  in  1  already-synchronized level from the upstream synchronizer
- ena  in  1  sample enable; when 0 the FSM, qualification counter and pulses are frozen/quiet
- cnt_clr  in  1  synchronous clear of `event_cnt`
- level_out  out  1  debounced level
- rise_pulse  out  1  one-cycle strobe on accepted 0->1
- fall_pulse  out  1  one-cycle strobe on accepted 1->0
- event_cnt  out  CNT_WIDTH  saturating count of accepted rising edges

## Operation
- Qualification counter `qcnt`: width clog2(DEBOUNCE_CYCLES+1).
- FSM states: LOW, QUAL_HI, HIGH, QUAL_LO. All transitions happen only on enabled cycles (ena=1).
- LOW: sync_in=1 -> if DEBOUNCE_CYCLES=1 go HIGH and fire rise, else go QUAL_HI with qcnt=1. sync_in=0 -> stay.
- QUAL_HI: sync_in=0 -> LOW, qcnt=0 (glitch rejected, no pulse). sync_in=1 and qcnt=DEBOUNCE_CYCLES-1 -> HIGH, qcnt=0, fire rise. Else qcnt+1.
- HIGH / QUAL_LO: mirror of LOW / QUAL_HI with polarity inverted; acceptance fires fall.
- `level_out` = 1 in HIGH and QUAL_LO, 0 in LOW and QUAL_HI (registered from state, glitch-free).
- `rise_pulse`/`fall_pulse`: registered, high for exactly the one cycle after the accepting edge, coincident with the `level_out` change; never both high.
- ena=0: state and qcnt hold, pulses forced 0 on the next cycle; a qualification in progress resumes where it stopped when ena returns.
- `event_cnt`: +1 on each cycle where a rise is accepted; saturates at 2^CNT_WIDTH-1 (no wrap).
- cnt_clr=1 alone -> event_cnt=0 next cycle. cnt_clr=1 coincident with an accepted rise -> event_cnt=1 (clear, then count).
- Reset (any time, including mid-qualification): state=LOW, qcnt=0, level_out=0, rise_pulse=0, fall_pulse=0, event_cnt=0. After release, a sync_in held high requires a full fresh qualification.

## Timing
- Latency: first enabled posedge sampling the new level = edge k; level_out and the pulse change after edge k+DEBOUNCE_CYCLES-1 (visible in cycle k+DEBOUNCE_CYCLES). DEBOUNCE_CYCLES=1: visible one cycle after sampling.
- Disabled cycles extend latency one-for-one.
- Minimum accepted-pulse spacing: rise and next fall separated by >= DEBOUNCE_CYCLES cycles.
- event_cnt updates in the same cycle rise_pulse is high.
- No combinational path from any input to any output.

## Configuration
- SYNC_DEBOUNCE_EVENT_CNT_EN defined: event counter, saturation logic and cnt_clr are compiled in as above.
- Not defined: no counter registers; `event_cnt` driven constant 0; cnt_clr ignored. All other behaviour identical.

## Test plan
- DEBOUNCE_CYCLES=4, ena=1: sync_in high for 3 cycles then low -> level_out stays 0, no rise_pulse, event_cnt=0.
- DEBOUNCE_CYCLES=4: sync_in rises and holds -> level_out=1 and rise_pulse=1 (single cycle) 4 cycles after first high sample; event_cnt=1; later hold low 4 cycles -> fall_pulse once, level_out=0.
- ena toggled 0 for 2 cycles mid-qualification of a held-high input -> acceptance delayed exactly 2 cycles, single rise_pulse.
- CNT_WIDTH=2, 5 accepted rises -> event_cnt 1,2,3,3,3; cnt_clr coincident with the 5th rise -> event_cnt=1.
- rst asserted low during QUAL_HI with qcnt=2 -> all outputs 0 immediately; after release, held-high input needs full 4 samples.
- DEBOUNCE_CYCLES=1: sync_in 0->1->0 on consecutive cycles -> rise_pulse then fall_pulse on consecutive cycles, level_out follows with 1-cycle delay.

Source files
------------

// File: rtl/sync_debounce_edge.sv
// Debounce and edge-qualify stage for an already-synchronized level input.
// Optional rising-edge event counter is compiled in with SYNC_DEBOUNCE_EVENT_CNT_EN.
module sync_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync_in,
    input  logic                 ena,
    input  logic                 cnt_clr,
    output logic                 level_out,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] event_cnt
);

    localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [QW-1:0] QLAST = QW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        QUAL_HI = 2'd1,
        HIGH    = 2'd2,
        QUAL_LO = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [QW-1:0]   qcnt, qcnt_nxt;
    logic            rise_nxt, fall_nxt, level_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOW;
            qcnt       <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            qcnt       <= qcnt_nxt;
            level_out  <= level_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (ena) begin
            case (state)
                LOW: begin
                    if (sync_in) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_nxt = HIGH;
                            rise_nxt  = 1'b1;
                        end else begin
                            state_nxt = QUAL_HI;
                            qcnt_nxt  = QW'(1);
                        end
                    end
                end
                QUAL_HI: begin
                    if (!sync_in) begin
                        state_nxt = LOW;
                        qcnt_nxt  = '0;
                    end else if (qcnt == QLAST) begin
                        state_nxt = HIGH;
                        qcnt_nxt  = '0;
                        rise_nxt  = 1'b1;
                    end else begin
                        qcnt_nxt = qcnt + QW'(1);
                    end
                end
                HIGH: begin
                    if (!sync_in) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_nxt = LOW;
                            fall_nxt  = 1'b1;
                        end else begin
                            state_nxt = QUAL_LO;
                            qcnt_nxt  = QW'(1);
                        end
                    end
                end
                QUAL_LO: begin
                    if (sync_in) begin
                        state_nxt = HIGH;
                        qcnt_nxt  = '0;
                    end else if (qcnt == QLAST) begin
                        state_nxt = LOW;
                        qcnt_nxt  = '0;
                        fall_nxt  = 1'b1;
                    end else begin
                        qcnt_nxt = qcnt + QW'(1);
                    end
                end
                default: begin
                    state_nxt = LOW;
                    qcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Level is registered from the next state so it flips together with the pulse.
    assign level_nxt = (state_nxt == HIGH) || (state_nxt == QUAL_LO);

`ifdef SYNC_DEBOUNCE_EVENT_CNT_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [CNT_WIDTH-1:0] cnt_q;

    // A clear coincident with an accepted rise still counts that rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= rise_nxt ? CNT_WIDTH'(1) : '0;
        end else if (rise_nxt) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign event_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign event_cnt      = '0;
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Scoreboard bench for sync_debounce_edge: a DEBOUNCE_CYCLES=4/CNT_WIDTH=2 instance
// and a DEBOUNCE_CYCLES=1/CNT_WIDTH=8 instance share stimulus, checked against a run-length model.
module tb_sync_debounce_edge;

`ifdef SYNC_DEBOUNCE_EVENT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sync_in = 1'b0;
    logic ena = 1'b0;
    logic cnt_clr = 1'b0;

    logic       level_a, rise_a, fall_a;
    logic [1:0] cnt_a;
    logic       level_b, rise_b, fall_b;
    logic [7:0] cnt_b;

    sync_debounce_edge #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(2)) dut_a (
        .clk(clk), .rst(rst), .sync_in(sync_in), .ena(ena), .cnt_clr(cnt_clr),
        .level_out(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .event_cnt(cnt_a)
    );

    sync_debounce_edge #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .sync_in(sync_in), .ena(ena), .cnt_clr(cnt_clr),
        .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .event_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       la, ra, fa;
        logic [1:0] ca;
        logic       lb, rb, fb;
        logic [7:0] cb;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    // Model state: accepted level, run of consecutive enabled samples disagreeing with it, count.
    logic m_lvl_a = 1'b0, m_lvl_b = 1'b0;
    int   m_run_a = 0, m_run_b = 0;
    int   m_cnt_a = 0, m_cnt_b = 0;

    task automatic model_step(input int d, input logic s, input logic en,
                              inout logic lvl, inout int run, output logic r, output logic f);
        r = 1'b0;
        f = 1'b0;
        if (en) begin
            if (s != lvl) begin
                run++;
                if (run == d) begin
                    lvl = ~lvl;
                    run = 0;
                    if (lvl) r = 1'b1;
                    else     f = 1'b1;
                end
            end else begin
                run = 0;
            end
        end
    endtask

    function automatic int count_step(input int cnt, input logic clr, input logic r, input int maxv);
        if (clr) return r ? 1 : 0;
        if (r && cnt < maxv) return cnt + 1;
        return cnt;
    endfunction

    // One cycle of stimulus: inputs applied at negedge, expected post-posedge outputs queued.
    task automatic cyc(input logic s, input logic en, input logic clr, input logic r_n);
        exp_t e;
        logic ra, fa, rb, fb;
        @(negedge clk);
        sync_in = s;
        ena     = en;
        cnt_clr = clr;
        if (!r_n) begin
            m_lvl_a = 1'b0; m_run_a = 0; m_cnt_a = 0;
            m_lvl_b = 1'b0; m_run_b = 0; m_cnt_b = 0;
            e = '0;
        end else begin
            model_step(4, s, en, m_lvl_a, m_run_a, ra, fa);
            model_step(1, s, en, m_lvl_b, m_run_b, rb, fb);
            m_cnt_a = count_step(m_cnt_a, clr, ra, 3);
            m_cnt_b = count_step(m_cnt_b, clr, rb, 255);
            e.la = m_lvl_a; e.ra = ra; e.fa = fa;
            e.ca = CNT_EN ? 2'(m_cnt_a) : 2'd0;
            e.lb = m_lvl_b; e.rb = rb; e.fb = fb;
            e.cb = CNT_EN ? 8'(m_cnt_b) : 8'd0;
        end
        q.push_back(e);
        if (!r_n && rst) begin
            rst = 1'b0;
            #1;
            n_vec++;
            if ({level_a, rise_a, fall_a, cnt_a, level_b, rise_b, fall_b, cnt_b} != '0) begin
                n_err++;
                $display("FAIL async_reset t=%0t got a=%b%b%b/%0d b=%b%b%b/%0d want all 0",
                         $time, level_a, rise_a, fall_a, cnt_a, level_b, rise_b, fall_b, cnt_b);
            end
        end else begin
            rst = r_n;
        end
    endtask

    // Monitor: every posedge produces one output sample to retire against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if ({level_a, rise_a, fall_a, cnt_a} != {e.la, e.ra, e.fa, e.ca}) begin
                    n_err++;
                    $display("FAIL dbc4 t=%0t got lvl=%b rise=%b fall=%b cnt=%0d want lvl=%b rise=%b fall=%b cnt=%0d",
                             $time, level_a, rise_a, fall_a, cnt_a, e.la, e.ra, e.fa, e.ca);
                end
                n_vec++;
                if ({level_b, rise_b, fall_b, cnt_b} != {e.lb, e.rb, e.fb, e.cb}) begin
                    n_err++;
                    $display("FAIL dbc1 t=%0t got lvl=%b rise=%b fall=%b cnt=%0d want lvl=%b rise=%b fall=%b cnt=%0d",
                             $time, level_b, rise_b, fall_b, cnt_b, e.lb, e.rb, e.fb, e.cb);
                end
            end
        end
    end

    initial begin
        logic s;
        int   budget;
        // Reset
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        // Glitch of 3 high samples rejected by the 4-cycle instance
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        // Full rise then full fall
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        // Enable dropped for 2 cycles mid-qualification
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        // Clear alone, then saturation and clear coincident with a rise
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) cyc(1'b1, 1'b1, (i == 5 && j == 3), 1'b1);
            for (int j = 0; j < 4; j++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        end
        // Reset during QUAL_HI with two samples taken, then fresh qualification
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        // Randomized: sticky input level with occasional flips, sparse disables/clears/resets
        s = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) s = ~s;
            cyc(s, ($urandom_range(7) != 0), ($urandom_range(31) == 0), ($urandom_range(149) != 0));
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain got %0d entries pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
